// File: rtl/vip_sobel_edge_3x3_8bit.sv
// Purpose: Sobel |gx|+|gy| magnitude of a 3x3 window, thresholded to a binary edge pixel stream.
// Latency: fixed 3 clk for data and for vsync/href/clken.
// Backpressure: none; the pipeline is free-running and clken only marks valid pixels.
// Optional: define SOBEL_GRAD_OUT_EN to drive post_img_y with min(mag,255) instead of 0/255.
module vip_sobel_edge_3x3_8bit #(
  parameter int BORDER_COLS = 2,
  parameter int BORDER_ROWS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        matrix_frame_vsync,
  input  logic        matrix_frame_href,
  input  logic        matrix_frame_clken,
  input  logic [7:0]  matrix_p11,
  input  logic [7:0]  matrix_p12,
  input  logic [7:0]  matrix_p13,
  input  logic [7:0]  matrix_p21,
  input  logic [7:0]  matrix_p22,
  input  logic [7:0]  matrix_p23,
  input  logic [7:0]  matrix_p31,
  input  logic [7:0]  matrix_p32,
  input  logic [7:0]  matrix_p33,
  input  logic [10:0] threshold,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_bit,
  output logic [7:0]  post_img_y
);

  // Weighted 1-2-1 sum of three taps; at most 4*255 = 1020, so 10 bits never overflow.
  function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Absolute difference as larger minus smaller, so the result can never wrap.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // The centre tap has zero weight in both kernels.
  logic unused_p22;
  assign unused_p22 = ^matrix_p22;

  // Input-side position tracking
  logic       vsync_q, href_q;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic       vsync_edge, href_fall, mask_in;

  assign vsync_edge = matrix_frame_vsync ^ vsync_q;
  assign href_fall  = href_q & ~matrix_frame_href;
  assign mask_in    = ({30'd0, col_q} < BORDER_COLS[31:0]) || ({30'd0, row_q} < BORDER_ROWS[31:0]);

  // Pipeline state
  logic [9:0]  gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic        mask1_q, mask2_q;
  logic [9:0]  gx_abs_q, gy_abs_q;
  logic [10:0] mag_d;
  logic        edge_d, edge_q;
  logic [2:0]  vsync_dly_q, href_dly_q, clken_dly_q;

  assign mag_d  = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
  assign edge_d = (mag_d >= threshold) && !mask2_q;

  // Next column/row count: vsync edge clear beats an href falling edge; both saturate at 3.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!matrix_frame_href) begin
      col_d = 2'd0;
    end else if (matrix_frame_clken && (col_q != 2'd3)) begin
      col_d = col_q + 2'd1;
    end
    if (vsync_edge) begin
      row_d = 2'd0;
    end else if (href_fall && (row_q != 2'd3)) begin
      row_d = row_q + 2'd1;
    end
  end

  // Position counters and previous sync levels used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
    end else begin
      vsync_q <= matrix_frame_vsync;
      href_q  <= matrix_frame_href;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // S1/S2: kernel half-sums, then their absolute differences, with the border mask alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p_q   <= '0;
      gx_n_q   <= '0;
      gy_p_q   <= '0;
      gy_n_q   <= '0;
      mask1_q  <= 1'b0;
      gx_abs_q <= '0;
      gy_abs_q <= '0;
      mask2_q  <= 1'b0;
    end else begin
      gx_p_q   <= tap_sum(matrix_p13, matrix_p23, matrix_p33);
      gx_n_q   <= tap_sum(matrix_p11, matrix_p21, matrix_p31);
      gy_p_q   <= tap_sum(matrix_p11, matrix_p12, matrix_p13);
      gy_n_q   <= tap_sum(matrix_p31, matrix_p32, matrix_p33);
      mask1_q  <= mask_in;
      gx_abs_q <= abs_diff(gx_p_q, gx_n_q);
      gy_abs_q <= abs_diff(gy_p_q, gy_n_q);
      mask2_q  <= mask1_q;
    end
  end

  // S3: thresholded edge decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= edge_d;
    end
  end

  // Sync signals ride a 3-deep shift register to stay aligned with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_dly_q <= '0;
      href_dly_q  <= '0;
      clken_dly_q <= '0;
    end else begin
      vsync_dly_q <= {vsync_dly_q[1:0], matrix_frame_vsync};
      href_dly_q  <= {href_dly_q[1:0], matrix_frame_href};
      clken_dly_q <= {clken_dly_q[1:0], matrix_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_dly_q[2];
  assign post_frame_href  = href_dly_q[2];
  assign post_frame_clken = clken_dly_q[2];
  assign post_img_bit     = edge_q & href_dly_q[2];

`ifdef SOBEL_GRAD_OUT_EN
  logic [7:0] grad_d, grad_q;

  assign grad_d = mask2_q ? 8'd0 : ((mag_d > 11'd255) ? 8'd255 : mag_d[7:0]);

  // S3: saturated gradient value, zero inside the border
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grad_q <= 8'd0;
    end else begin
      grad_q <= grad_d;
    end
  end

  assign post_img_y = href_dly_q[2] ? grad_q : 8'd0;
`else
  assign post_img_y = {8{post_img_bit}};
`endif

endmodule

// File: tb/tb_vip_sobel_edge_3x3_8bit.sv
module tb_vip_sobel_edge_3x3_8bit;

  localparam int BC = 2;
  localparam int BR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vs, in_hr, in_ce;
  logic [71:0] win_r;
  logic [10:0] thr;
  logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
  logic [7:0]  post_img_y;

  int n_cmp = 0;
  int n_err = 0;
  bit sb_en = 1'b0;

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic        ce;
    logic        mask;
    logic [10:0] mag;
  } sb_t;

  sb_t sb[$];

  // Reference model state for border position
  int   col_m, row_m;
  logic vs_prev, hr_prev;

  logic [71:0] w_flat, w_vstep, w_200;

  always #5 clk = ~clk;

  vip_sobel_edge_3x3_8bit #(.BORDER_COLS(BC), .BORDER_ROWS(BR)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (in_vs),
    .matrix_frame_href  (in_hr),
    .matrix_frame_clken (in_ce),
    .matrix_p11         (win_r[7:0]),
    .matrix_p12         (win_r[15:8]),
    .matrix_p13         (win_r[23:16]),
    .matrix_p21         (win_r[31:24]),
    .matrix_p22         (win_r[39:32]),
    .matrix_p23         (win_r[47:40]),
    .matrix_p31         (win_r[55:48]),
    .matrix_p32         (win_r[63:56]),
    .matrix_p33         (win_r[71:64]),
    .threshold          (thr),
    .post_frame_vsync   (post_frame_vsync),
    .post_frame_href    (post_frame_href),
    .post_frame_clken   (post_frame_clken),
    .post_img_bit       (post_img_bit),
    .post_img_y         (post_img_y)
  );

  // Tap k in row-major order: 0 = p11 ... 8 = p33
  function automatic int px(input logic [71:0] w, input int k);
    return int'(w[8*k +: 8]);
  endfunction

  function automatic logic [71:0] mkwin(input logic [7:0] p11, input logic [7:0] p12, input logic [7:0] p13,
                                        input logic [7:0] p21, input logic [7:0] p22, input logic [7:0] p23,
                                        input logic [7:0] p31, input logic [7:0] p32, input logic [7:0] p33);
    return {p33, p32, p31, p23, p22, p21, p13, p12, p11};
  endfunction

  // Signed Sobel gradients, magnitude as |gx|+|gy|
  function automatic logic [10:0] ref_mag(input logic [71:0] w);
    int gx, gy;
    gx = (px(w, 2) + 2 * px(w, 5) + px(w, 8)) - (px(w, 0) + 2 * px(w, 3) + px(w, 6));
    gy = (px(w, 0) + 2 * px(w, 1) + px(w, 2)) - (px(w, 6) + 2 * px(w, 7) + px(w, 8));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return 11'(gx + gy);
  endfunction

  // Scoreboard: each entry becomes due three clocks after its inputs are sampled
  sb_t         mon_e;
  logic        mon_bit;
  logic [7:0]  mon_y;
  logic [11:0] mon_exp, mon_got;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_en && sb.size() >= 3) begin
        mon_e   = sb.pop_front();
        mon_bit = mon_e.hr && !mon_e.mask && (mon_e.mag >= thr);
`ifdef SOBEL_GRAD_OUT_EN
        mon_y   = (mon_e.hr && !mon_e.mask) ? ((mon_e.mag > 11'd255) ? 8'd255 : mon_e.mag[7:0]) : 8'd0;
`else
        mon_y   = {8{mon_bit}};
`endif
        mon_exp = {mon_e.vs, mon_e.hr, mon_e.ce, mon_bit, mon_y};
        mon_got = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_y};
        n_cmp++;
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL stream t=%0t vs/hr/ce/bit/y got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d", $time,
                   mon_got[11], mon_got[10], mon_got[9], mon_got[8], mon_got[7:0],
                   mon_exp[11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  // Apply one cycle of input, record its expectation, return at negedge+1
  task automatic drive_cycle(input logic vs, input logic hr, input logic ce, input logic [71:0] w);
    sb_t e;
    in_vs  = vs;
    in_hr  = hr;
    in_ce  = ce;
    win_r  = w;
    e.vs   = vs;
    e.hr   = hr;
    e.ce   = ce;
    e.mask = (row_m < BR) || (col_m < BC);
    e.mag  = ref_mag(w);
    if (!hr) col_m = 0;
    else if (ce && col_m < 3) col_m++;
    if (vs != vs_prev) row_m = 0;
    else if (hr_prev && !hr && row_m < 3) row_m++;
    vs_prev = vs;
    hr_prev = hr;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    in_vs = 1'b0; in_hr = 1'b0; in_ce = 1'b0; win_r = '0;
    col_m = 0; row_m = 0; vs_prev = 1'b0; hr_prev = 1'b0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    rst_n = 1'b1;
    sb_en = 1'b1;
  endtask

  // One line of npix valid pixels (optionally with a gap after each), then 4 idle cycles
  task automatic run_line(input int npix, input logic [71:0] w, input bit gaps, output int nbit, output int ny);
    int nact;
    logic hr, ce;
    nbit = 0;
    ny   = 0;
    nact = gaps ? 2 * npix : npix;
    for (int c = 0; c < nact + 4; c++) begin
      hr = (c < nact);
      ce = hr && (!gaps || (c % 2 == 0));
      drive_cycle(1'b0, hr, ce, w);
      if (post_frame_clken && post_img_bit) nbit++;
      if (post_frame_clken && post_img_y == 8'd255) ny++;
    end
  endtask

  task automatic frame_start();
    drive_cycle(1'b1, 1'b0, 1'b0, w_flat);
    drive_cycle(1'b1, 1'b0, 1'b0, w_flat);
    drive_cycle(1'b0, 1'b0, 1'b0, w_flat);
    drive_cycle(1'b0, 1'b0, 1'b0, w_flat);
  endtask

  // New frame plus two lines so the row border is behind us
  task automatic prime();
    int nb_unused, ny_unused;
    frame_start();
    run_line(6, w_flat, 1'b0, nb_unused, ny_unused);
    run_line(6, w_flat, 1'b0, nb_unused, ny_unused);
  endtask

  task automatic test_reset();
    int first;
    logic [11:0] outs;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_vs = 1'($urandom); in_hr = 1'($urandom); in_ce = 1'($urandom);
      win_r = {8'($urandom), 32'($urandom), 32'($urandom)};
      thr   = 11'($urandom);
      @(posedge clk);
      @(negedge clk);
      #1;
      outs = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_y};
      n_cmp++;
      if (outs !== 12'd0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d outputs %h required 000", i, outs);
      end
    end
    thr = 11'd128;
    release_reset();
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, w_flat);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, w_vstep);
      if (first == 0 && post_frame_href) first = i;
    end
    n_cmp++;
    if (first != 3) begin
      n_err++;
      $display("FAIL reset_latency first href change after %0d clk required 3", first);
    end
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, w_flat);
  endtask

  task automatic test_flat();
    int nb, ny;
    thr = 11'd1;
    prime();
    run_line(6, w_flat, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 0) begin n_err++; $display("FAIL flat_bit edges %0d required 0", nb); end
    n_cmp++;
    if (ny != 0) begin n_err++; $display("FAIL flat_y y255 count %0d required 0", ny); end
  endtask

  task automatic test_vstep();
    int nb, ny;
    thr = 11'd128;
    run_line(6, w_vstep, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 4) begin n_err++; $display("FAIL vstep_bit edges %0d required 4", nb); end
    n_cmp++;
    if (ny != 4) begin n_err++; $display("FAIL vstep_y y255 count %0d required 4", ny); end
  endtask

  task automatic test_threshold();
    int nb, ny;
    thr = 11'd200;
    run_line(6, w_200, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 4) begin n_err++; $display("FAIL thr_equal edges %0d required 4", nb); end
    thr = 11'd201;
    run_line(6, w_200, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 0) begin n_err++; $display("FAIL thr_above edges %0d required 0", nb); end
  endtask

  task automatic test_frame();
    int nb, ny, exp_n;
    thr = 11'd128;
    frame_start();
    for (int l = 0; l < 8; l++) begin
      run_line(8, w_vstep, 1'b0, nb, ny);
      exp_n = (l < 2) ? 0 : 6;
      n_cmp++;
      if (nb != exp_n) begin n_err++; $display("FAIL frame_line%0d edges %0d required %0d", l, nb, exp_n); end
      n_cmp++;
      if (ny != exp_n) begin n_err++; $display("FAIL frame_line%0d y255 %0d required %0d", l, ny, exp_n); end
    end
  endtask

  task automatic test_clken_gap();
    int nb, ny;
    prime();
    run_line(6, w_vstep, 1'b1, nb, ny);
    n_cmp++;
    if (nb != 4) begin n_err++; $display("FAIL clken_gap edges %0d required 4", nb); end
  endtask

  task automatic test_href_low();
    int nz;
    nz = 0;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, 1'b0, (i < 6), w_vstep);
      if (post_img_bit || post_img_y != 8'd0) nz++;
    end
    n_cmp++;
    if (nz != 0) begin n_err++; $display("FAIL href_low nonzero outputs %0d required 0", nz); end
  endtask

  task automatic test_vsync_restart();
    int nb, ny, exp_n;
    frame_start();
    for (int l = 0; l < 3; l++) run_line(6, w_vstep, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 4) begin n_err++; $display("FAIL vsync_pre line2 edges %0d required 4", nb); end
    frame_start();
    for (int l = 0; l < 3; l++) begin
      run_line(6, w_vstep, 1'b0, nb, ny);
      exp_n = (l < 2) ? 0 : 4;
      n_cmp++;
      if (nb != exp_n) begin n_err++; $display("FAIL vsync_restart line%0d edges %0d required %0d", l, nb, exp_n); end
    end
  endtask

  task automatic test_reset_midframe();
    int nb, ny;
    logic [11:0] outs;
    prime();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b1, w_vstep);
    n_cmp++;
    if (post_img_bit !== 1'b1) begin n_err++; $display("FAIL midframe_pre bit %b required 1", post_img_bit); end
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    outs = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit, post_img_y};
    n_cmp++;
    if (outs !== 12'd0) begin n_err++; $display("FAIL midframe_reset outputs %h required 000", outs); end
    @(posedge clk);
    @(negedge clk);
    #1;
    release_reset();
    run_line(6, w_vstep, 1'b0, nb, ny);
    n_cmp++;
    if (nb != 0) begin n_err++; $display("FAIL midframe_after edges %0d required 0", nb); end
  endtask

  initial begin
    rst_n   = 1'b1;
    in_vs   = 1'b0; in_hr = 1'b0; in_ce = 1'b0;
    win_r   = '0;
    thr     = '0;
    col_m   = 0; row_m = 0; vs_prev = 1'b0; hr_prev = 1'b0;
    w_flat  = {9{8'd100}};
    w_vstep = mkwin(8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255);
    w_200   = mkwin(8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50);
    test_reset();
    test_flat();
    test_vstep();
    test_threshold();
    test_frame();
    test_clken_gap();
    test_href_low();
    test_vsync_restart();
    test_reset_midframe();
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, w_flat);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
